// File: rtl/move_commit_ctrl_pkg.sv
// move_commit_ctrl_pkg: shared direction and FSM encodings, default map geometry,
// and the off-map edge test used when a move request is launched.
package move_commit_ctrl_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam int DEF_MAP_W      = 13;
    localparam int DEF_NUM_FLOORS = 10;

    typedef enum logic [2:0] {IDLE, READ, RESOLVE, WRITE, DONE} state_t;

    function automatic logic off_map(input logic [3:0] x, input logic [3:0] y, input logic [1:0] d, input int w);
        logic [3:0] last;
        last = 4'(w - 1);
        return (d == DIR_UP && y == 4'd0) || (d == DIR_DOWN && y == last) ||
               (d == DIR_LEFT && x == 4'd0) || (d == DIR_RIGHT && x == last);
    endfunction

endpackage

// File: rtl/move_commit_ctrl_map_addr_gen.sv
// map_addr_gen: combinational floor/x/y to linear map RAM address, floor-major then row-major.
module map_addr_gen
    import move_commit_ctrl_pkg::*;
#(
    parameter int MAP_W = DEF_MAP_W
) (
    input  logic [15:0] floor_i,
    input  logic [3:0]  x_i,
    input  logic [3:0]  y_i,
    output logic [15:0] addr_o
);

    assign addr_o = floor_i * 16'(MAP_W * MAP_W) + {12'd0, y_i} * 16'(MAP_W) + {12'd0, x_i};

endmodule

// File: rtl/move_commit_ctrl.sv
// move_commit_ctrl: one-step move front end; reads the target tile, hands it to the resolver
// and commits the results. Define MOVE_CTRL_BUF_EN for a one-entry request buffer.
module move_commit_ctrl
    import move_commit_ctrl_pkg::*;
#(
    parameter int MAP_W        = DEF_MAP_W,
    parameter int NUM_FLOORS   = DEF_NUM_FLOORS,
    parameter int RD_LAT       = 1,
    parameter int START_X      = 6,
    parameter int START_Y      = 11,
    parameter int START_FLOOR  = 0,
    parameter int START_HEALTH = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        move_valid,
    input  logic [1:0]  move_dir,
    output logic        move_ready,
    output logic        move_done,
    output logic        move_rejected,
    output logic [15:0] map_addr,
    input  logic [15:0] map_rd_data,
    output logic        map_we,
    output logic [15:0] map_wr_data,
    output logic [3:0]  rs_pos_x,
    output logic [3:0]  rs_pos_y,
    output logic [15:0] rs_tile_id,
    input  logic [15:0] rs_floor_out,
    input  logic [3:0]  rs_goto_x,
    input  logic [3:0]  rs_goto_y,
    input  logic [31:0] rs_key_num_out,
    input  logic [15:0] rs_health_out,
    input  logic [15:0] rs_new_tile_id,
    output logic [15:0] floor,
    output logic [3:0]  player_x,
    output logic [3:0]  player_y,
    output logic [31:0] key_num,
    output logic [15:0] health
);

    state_t      state_q;
    logic [1:0]  cnt_q;
    logic        launch, off, bad_floor, keep;
    logic [1:0]  dir;
    logic [3:0]  tx, ty;
    logic [15:0] tgt_addr;

`ifdef MOVE_CTRL_BUF_EN
    logic       buf_v_q;
    logic [1:0] buf_dir_q;
    logic       accept;

    assign move_ready = !buf_v_q;
    assign accept     = move_valid && move_ready;
    assign dir        = buf_v_q ? buf_dir_q : move_dir;
    assign launch     = (state_q == IDLE && (buf_v_q || move_valid)) || (state_q == DONE && buf_v_q);

    // Anything accepted outside IDLE waits here until DONE/IDLE launches it.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_v_q   <= 1'b0;
            buf_dir_q <= DIR_UP;
        end else if (accept && state_q != IDLE) begin
            buf_v_q   <= 1'b1;
            buf_dir_q <= move_dir;
        end else if (launch) begin
            buf_v_q   <= 1'b0;
        end
    end
`else
    assign move_ready = (state_q == IDLE);
    assign dir        = move_dir;
    assign launch     = move_valid && move_ready;
`endif

    assign tx        = dir == DIR_LEFT ? player_x - 4'd1 : dir == DIR_RIGHT ? player_x + 4'd1 : player_x;
    assign ty        = dir == DIR_UP ? player_y - 4'd1 : dir == DIR_DOWN ? player_y + 4'd1 : player_y;
    assign off       = off_map(player_x, player_y, dir, MAP_W);
    assign bad_floor = rs_floor_out >= 16'(NUM_FLOORS);
    assign keep      = rs_goto_x == player_x && rs_goto_y == player_y && rs_floor_out == floor &&
                       rs_key_num_out == key_num && rs_health_out == health && rs_new_tile_id == rs_tile_id;

    map_addr_gen #(.MAP_W(MAP_W)) u_addr (
        .floor_i (floor),
        .x_i     (tx),
        .y_i     (ty),
        .addr_o  (tgt_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= 2'd0;
            move_done     <= 1'b0;
            move_rejected <= 1'b0;
            map_we        <= 1'b0;
            map_addr      <= 16'd0;
            map_wr_data   <= 16'd0;
            rs_pos_x      <= 4'd0;
            rs_pos_y      <= 4'd0;
            rs_tile_id    <= 16'd0;
            player_x      <= 4'(START_X);
            player_y      <= 4'(START_Y);
            floor         <= 16'(START_FLOOR);
            key_num       <= 32'd0;
            health        <= 16'(START_HEALTH);
        end else begin
            move_done <= 1'b0;
            map_we    <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    state_q <= IDLE;
                    if (launch && off) begin
                        state_q       <= DONE;
                        move_done     <= 1'b1;
                        move_rejected <= 1'b1;
                    end else if (launch) begin
                        state_q  <= READ;
                        cnt_q    <= 2'd0;
                        rs_pos_x <= tx;
                        rs_pos_y <= ty;
                        map_addr <= tgt_addr;
                    end
                end
                READ: begin
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == 2'(RD_LAT - 1)) begin
                        rs_tile_id <= map_rd_data;
                        state_q    <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    if (bad_floor) begin
                        state_q       <= DONE;
                        move_done     <= 1'b1;
                        move_rejected <= 1'b1;
                    end else begin
                        player_x      <= rs_goto_x;
                        player_y      <= rs_goto_y;
                        floor         <= rs_floor_out;
                        key_num       <= rs_key_num_out;
                        health        <= rs_health_out;
                        move_rejected <= keep;
                        // map_addr still holds the target on the pre-move floor for the write-back.
                        if (rs_new_tile_id != rs_tile_id) begin
                            state_q     <= WRITE;
                            map_we      <= 1'b1;
                            map_wr_data <= rs_new_tile_id;
                        end else begin
                            state_q   <= DONE;
                            move_done <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    state_q   <= DONE;
                    move_done <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_move_commit_ctrl.sv
// tb_move_commit_ctrl: scoreboard bench for move_commit_ctrl with a stand-in resolver and map RAM.
`timescale 1ns/1ps
module tb_move_commit_ctrl;

    localparam int RD_LAT = 1;
    localparam logic [15:0] GROUND = 16'd0, WALL = 16'd1, KEY = 16'd2, UPST = 16'd3, DNST = 16'd4;
    localparam logic [1:0] UP = 2'd0, LEFT = 2'd2, RIGHT = 2'd3;
`ifdef MOVE_CTRL_BUF_EN
    localparam int BUF = 1;
`else
    localparam int BUF = 0;
`endif

    typedef struct {
        string name;
        int    rej, x, y, fl, key, hp, nwr, waddr, lat, t;
    } exp_t;

    logic        clk, rst, move_valid, move_ready, move_done, move_rejected, map_we;
    logic [1:0]  move_dir;
    logic [15:0] map_addr, map_rd_data, map_wr_data, rs_tile_id, rs_floor_out, rs_health_out, rs_new_tile_id;
    logic [15:0] floor, health;
    logic [3:0]  rs_pos_x, rs_pos_y, rs_goto_x, rs_goto_y, player_x, player_y;
    logic [31:0] rs_key_num_out, key_num;

    logic [15:0] mem [0:2047];
    exp_t        sb[$];
    exp_t        me;
    int          cyc = 0, nvec = 0, nerr = 0, wr_n = 0;
    logic [15:0] wr_a, wr_d;

    move_commit_ctrl #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .move_valid(move_valid), .move_dir(move_dir), .move_ready(move_ready),
        .move_done(move_done), .move_rejected(move_rejected), .map_addr(map_addr), .map_rd_data(map_rd_data),
        .map_we(map_we), .map_wr_data(map_wr_data), .rs_pos_x(rs_pos_x), .rs_pos_y(rs_pos_y),
        .rs_tile_id(rs_tile_id), .rs_floor_out(rs_floor_out), .rs_goto_x(rs_goto_x), .rs_goto_y(rs_goto_y),
        .rs_key_num_out(rs_key_num_out), .rs_health_out(rs_health_out), .rs_new_tile_id(rs_new_tile_id),
        .floor(floor), .player_x(player_x), .player_y(player_y), .key_num(key_num), .health(health)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign map_rd_data = mem[map_addr[10:0]];

    // Stand-in resolver: ground walks, wall blocks, key is picked up, stairs change floor.
    always_comb begin
        rs_goto_x      = rs_pos_x;
        rs_goto_y      = rs_pos_y;
        rs_floor_out   = floor;
        rs_key_num_out = key_num;
        rs_health_out  = health;
        rs_new_tile_id = rs_tile_id;
        case (rs_tile_id)
            WALL: begin rs_goto_x = player_x; rs_goto_y = player_y; end
            KEY:  begin rs_key_num_out = key_num + 32'd1; rs_health_out = health - 16'd5; rs_new_tile_id = GROUND; end
            UPST: begin rs_floor_out = floor + 16'd1; rs_goto_x = 4'd1; rs_goto_y = 4'd2; end
            DNST: begin rs_floor_out = floor - 16'd1; rs_goto_x = 4'd3; rs_goto_y = 4'd4; end
            default: ;
        endcase
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        nvec++;
        if (act !== exp_v) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    function automatic exp_t mk(string n, int r, int x, int y, int f, int k, int h, int w, int wa, int l);
        exp_t e;
        e.name = n; e.rej = r; e.x = x; e.y = y; e.fl = f; e.key = k; e.hp = h;
        e.nwr = w; e.waddr = wa; e.lat = l; e.t = 0;
        return e;
    endfunction

    task automatic issue(input logic [1:0] d, input exp_t e, input bit b2b);
        int n = 0;
        while (!b2b && (sb.size() != 0 || move_done || !move_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!move_ready) begin
            check({e.name, ".ready"}, 32'(move_ready), 32'd1);
            return;
        end
        move_valid = 1'b1;
        move_dir   = d;
        @(posedge clk);
        e.t = cyc;
        sb.push_back(e);
        @(negedge clk);
        move_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || move_done) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic check_reset(input string nm);
        check({nm, ".ready"}, 32'(move_ready), 32'd1);
        check({nm, ".done"}, 32'(move_done), 32'd0);
        check({nm, ".we"}, 32'(map_we), 32'd0);
        check({nm, ".addr"}, 32'(map_addr), 32'd0);
        check({nm, ".wdata"}, 32'(map_wr_data), 32'd0);
        check({nm, ".x"}, 32'(player_x), 32'd6);
        check({nm, ".y"}, 32'(player_y), 32'd11);
        check({nm, ".floor"}, 32'(floor), 32'd0);
        check({nm, ".key"}, key_num, 32'd0);
        check({nm, ".hp"}, 32'(health), 32'd100);
    endtask

    always @(negedge clk) begin
        if (map_we) begin
            wr_n++;
            wr_a = map_addr;
            wr_d = map_wr_data;
            mem[map_addr[10:0]] = map_wr_data;
        end
        if (move_done) begin
            if (sb.size() == 0) check("unexpected_done", 32'(move_done), 32'd0);
            else begin
                me = sb.pop_front();
                check({me.name, ".rej"}, 32'(move_rejected), 32'(me.rej));
                check({me.name, ".x"}, 32'(player_x), 32'(me.x));
                check({me.name, ".y"}, 32'(player_y), 32'(me.y));
                check({me.name, ".floor"}, 32'(floor), 32'(me.fl));
                check({me.name, ".key"}, key_num, 32'(me.key));
                check({me.name, ".hp"}, 32'(health), 32'(me.hp));
                check({me.name, ".writes"}, 32'(wr_n), 32'(me.nwr));
                check({me.name, ".latency"}, 32'(cyc - me.t), 32'(me.lat));
                if (me.nwr > 0) begin
                    check({me.name, ".waddr"}, 32'(wr_a), 32'(me.waddr));
                    check({me.name, ".wdata"}, 32'(wr_d), 32'(GROUND));
                end
            end
            wr_n = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t beyond limit 200000", $time);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = GROUND;
        rst = 1'b1;
        move_valid = 1'b0;
        move_dir = UP;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset("reset");
        check("reset.rej", 32'(move_rejected), 32'd0);
        mem[151] = WALL;
        mem[136] = KEY;
        issue(RIGHT, mk("ground", 0, 7, 11, 0, 0, 100, 0, 0, RD_LAT + 2), 0);
        check("busy_ready", 32'(move_ready), 32'(BUF));
        issue(RIGHT, mk("wall", 1, 7, 11, 0, 0, 100, 0, 0, RD_LAT + 2), 0);
        issue(LEFT, mk("back", 0, 6, 11, 0, 0, 100, 0, 0, RD_LAT + 2), 0);
        issue(UP, mk("key", 0, 6, 10, 0, 1, 95, 1, 136, RD_LAT + 3), 0);
        for (int i = 5; i >= 0; i--) issue(LEFT, mk("walk", 0, i, 10, 0, 1, 95, 0, 0, RD_LAT + 2), 0);
        drain();
        check("walk_addr", 32'(map_addr), 32'd130);
        issue(LEFT, mk("edge", 1, 0, 10, 0, 1, 95, 0, 0, 1), 0);
        drain();
        check("edge_addr", 32'(map_addr), 32'd130);
        mem[117] = DNST;
        issue(UP, mk("dnstair_f0", 1, 0, 10, 0, 1, 95, 0, 0, RD_LAT + 2), 0);
        mem[131] = UPST;
        mem[197] = UPST;
        mem[366] = UPST;
        mem[535] = UPST;
        issue(RIGHT, mk("up_f1", 0, 1, 2, 1, 1, 95, 0, 0, RD_LAT + 2), 0);
        issue(RIGHT, mk("up_f2", 0, 1, 2, 2, 1, 95, 0, 0, RD_LAT + 2), 0);
        issue(RIGHT, mk("up_f3", 0, 1, 2, 3, 1, 95, 0, 0, RD_LAT + 2), 0);
        issue(RIGHT, mk("up_f4", 0, 1, 2, 4, 1, 95, 0, 0, RD_LAT + 2), 0);
        drain();
        move_valid = 1'b1;
        move_dir = RIGHT;
        @(posedge clk);
        @(negedge clk);
        move_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset("mid_reset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_reset_we", 32'(map_we), 32'd0);
        end
        issue(LEFT, mk("b2b_1", 0, 5, 11, 0, 0, 100, 0, 0, RD_LAT + 2), 0);
`ifdef MOVE_CTRL_BUF_EN
        issue(LEFT, mk("b2b_2", 0, 4, 11, 0, 0, 100, 0, 0, 2 * RD_LAT + 3), 1);
`else
        issue(LEFT, mk("b2b_2", 0, 4, 11, 0, 0, 100, 0, 0, RD_LAT + 2), 0);
`endif
        drain();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
